// File: rtl/ring_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } meas_state_t;

  localparam int unsigned SETTLE_CYCLES = 3;
  localparam int unsigned SETTLE_W      = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on a
// synchronized rising edge of an asynchronous input.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts synchronized rising edges of one selected ring-oscillator tap over a
// programmable window of clk cycles; result held until the next measurement.
module ring_osc_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int unsigned N_OSC  = 7,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned GATE_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_OSC-1:0]  osc_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  meas_state_t          state_q, state_d;
  logic [SEL_W-1:0]     sel_q;
  logic [GATE_W-1:0]    gate_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]     edge_cnt, edge_cnt_d;
  logic                 ovf_flag, ovf_d;
  logic                 osc_sel;
  logic                 rise;
  logic                 accept;

  // Out-of-range selects fall through to constant 0.
  always_comb begin
    osc_sel = 1'b0;
    for (int unsigned i = 0; i < N_OSC; i++) begin
      if (sel_q == SEL_W'(i)) osc_sel = osc_in[i];
    end
  end

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (osc_sel),
    .rise (rise)
  );

  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == '0) state_d = (gate_cnt == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (gate_cnt == GATE_W'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_cnt_d = edge_cnt;
    ovf_d      = ovf_flag;
    if ((state_q == MEASURE) && rise) begin
      if (edge_cnt == '1) ovf_d = 1'b1;
      else                edge_cnt_d = edge_cnt + CNT_W'(1);
    end
  end

  // Results load on the transition into DONE so they are already valid
  // during the DONE cycle, including the final MEASURE cycle's edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        sel_q      <= sel;
        gate_cnt   <= gate_len;
        settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
        edge_cnt   <= '0;
        ovf_flag   <= 1'b0;
      end else begin
        edge_cnt <= edge_cnt_d;
        ovf_flag <= ovf_d;
        if (state_q == SETTLE)  settle_cnt <= settle_cnt - SETTLE_W'(1);
        if (state_q == MEASURE) gate_cnt   <= gate_cnt - GATE_W'(1);
      end
      if (state_d == DONE) begin
        count    <= edge_cnt_d;
        overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Randomized self-checking bench: two meters (16-bit and 4-bit counters) share
// stimulus and are compared every cycle against a sample-history model.
module tb_ring_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  osc_in = '0;
  logic [2:0]  sel = '0;
  logic [15:0] gate_len = '0;
  logic        start = 1'b0;

  logic        busy16, done16, ovf16;
  logic [15:0] cnt16;
  logic        busy4, done4, ovf4;
  logic [3:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  int osc_per [7] = '{default: 0};   // 0 means random per-cycle level
  int osc_ph  [7] = '{default: 0};
  int osc_n = 0;

  // Model state: tap samples per posedge, current run parameters, held results.
  logic [6:0]  hist [0:32767];
  int          e = 0;
  bit          run_active = 1'b0;
  int          t0 = 0;
  int          run_g = 0;
  logic [2:0]  run_sel = '0;
  int          raw = 0;
  logic [15:0] res16_cnt = '0;
  logic        res16_ovf = 1'b0;
  logic [3:0]  res4_cnt = '0;
  logic        res4_ovf = 1'b0;

  ring_osc_freq_meter #(.N_OSC(7), .SEL_W(3), .GATE_W(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .sel(sel), .gate_len(gate_len),
    .start(start), .busy(busy16), .done(done16), .count(cnt16), .overflow(ovf16)
  );

  ring_osc_freq_meter #(.N_OSC(7), .SEL_W(3), .GATE_W(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .sel(sel), .gate_len(gate_len),
    .start(start), .busy(busy4), .done(done4), .count(cnt4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit xs(input int j);
    logic [6:0] v;
    v = hist[(t0 + j) & 32767];
    return (run_sel < 3'd7) ? v[run_sel] : 1'b0;
  endfunction

  // Oscillator taps change only on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      osc_n++;
      for (int i = 0; i < 7; i++) begin
        if (osc_per[i] == 0) osc_in[i] = 1'($urandom_range(0, 1));
        else osc_in[i] = (((osc_n + osc_ph[i]) % osc_per[i]) < (osc_per[i] / 2));
      end
    end
  end

  // Reference model: a window of G cycles counts 0->1 transitions between
  // consecutive samples 1..G+1 taken after the start edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        run_active = 1'b0;
        res16_cnt = '0; res16_ovf = 1'b0;
        res4_cnt  = '0; res4_ovf  = 1'b0;
      end else begin
        hist[e & 32767] = osc_in;
        if (start && (!run_active || e >= t0 + 5 + run_g)) begin
          t0 = e; run_g = int'(gate_len); run_sel = sel; run_active = 1'b1;
        end else if (run_active && e == t0 + 3 + run_g) begin
          raw = 0;
          for (int m = 3; m <= 2 + run_g; m++)
            if (xs(m - 1) && !xs(m - 2)) raw++;
          res16_cnt = (raw > 65535) ? 16'hFFFF : 16'(raw);
          res16_ovf = (raw > 65535);
          res4_cnt  = (raw > 15) ? 4'hF : 4'(raw);
          res4_ovf  = (raw > 15);
        end
      end
      e++;
    end
  end

  // Every-cycle comparison of both meters against the model.
  initial begin
    int  rel;
    bit  eb, ed;
    forever begin
      @(negedge clk);
      rel = e - t0;
      eb = !rst && run_active && rel >= 1 && rel <= 3 + run_g;
      ed = !rst && run_active && rel == 4 + run_g;
      chk("busy16", busy16, eb);
      chk("done16", done16, ed);
      chk("count16", cnt16, rst ? 16'h0 : res16_cnt);
      chk("ovf16", ovf16, rst ? 1'b0 : res16_ovf);
      chk("busy4", busy4, eb);
      chk("done4", done4, ed);
      chk("count4", cnt4, rst ? 4'h0 : res4_cnt);
      chk("ovf4", ovf4, rst ? 1'b0 : res4_ovf);
    end
  end

  task automatic run_meas(input logic [2:0] s, input int g, input bit lockout,
                          output int lat, output int dones);
    @(negedge clk);
    sel = s; gate_len = 16'(g); start = 1'b1;
    @(negedge clk);
    start = 1'b0; sel = 3'($urandom); gate_len = 16'($urandom);
    lat = 1; dones = 0;
    while (lat < g + 40 && !done16) begin
      if (lockout && lat == 10) begin
        start = 1'b1; sel = 3'd5; gate_len = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done16, 1'b1);
    chk("done_latency", lat, 4 + g);
    if (done16) dones = 1;
    repeat (3) begin
      @(negedge clk);
      if (done16) dones++;
    end
  endtask

  initial begin
    int lat, dones;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy16, 1'b0);
    chk("reset_done", done16, 1'b0);
    chk("reset_count", cnt16, 16'h0);
    chk("reset_ovf", ovf16, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Period-8 square wave on tap 2, 64-cycle window.
    osc_per[2] = 8; osc_per[3] = 4;
    run_meas(3'd2, 64, 1'b0, lat, dones);
    chk("measure_range", (cnt16 >= 16'd7 && cnt16 <= 16'd9), 1'b1);
    chk("measure_model", (res16_cnt >= 16'd7 && res16_cnt <= 16'd9), 1'b1);
    chk("measure_ovf", ovf16, 1'b0);

    // Period-4 wave, 100-cycle window saturates the 4-bit meter.
    run_meas(3'd3, 100, 1'b0, lat, dones);
    chk("sat_count4", cnt4, 4'hF);
    chk("sat_ovf4", ovf4, 1'b1);
    chk("sat_range16", (cnt16 >= 16'd24 && cnt16 <= 16'd26), 1'b1);
    chk("sat_ovf16", ovf16, 1'b0);

    // Zero-length window.
    run_meas(3'd3, 0, 1'b0, lat, dones);
    chk("zero_count", cnt16, 16'h0);
    chk("zero_ovf4", ovf4, 1'b0);

    // Second start mid-run is ignored.
    run_meas(3'd2, 64, 1'b1, lat, dones);
    chk("lockout_dones", dones, 1);
    chk("lockout_range", (cnt16 >= 16'd7 && cnt16 <= 16'd9), 1'b1);

    // Asynchronous reset in MEASURE clears held results at once.
    @(negedge clk);
    sel = 3'd3; gate_len = 16'd80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_now", busy16, 1'b0);
    chk("rst_count_now", cnt16, 16'h0);
    chk("rst_count4_now", cnt4, 4'h0);
    chk("rst_ovf_now", ovf4, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    run_meas(3'd2, 64, 1'b0, lat, dones);
    chk("post_rst_range", (cnt16 >= 16'd7 && cnt16 <= 16'd9), 1'b1);

    // Invalid select with every tap toggling.
    for (int i = 0; i < 7; i++) osc_per[i] = 0;
    run_meas(3'd7, 50, 1'b0, lat, dones);
    chk("badsel_count", cnt16, 16'h0);
    chk("badsel_ovf", ovf16, 1'b0);

    // Randomized windows, taps and selects.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 7; i++) begin
        osc_per[i] = $urandom_range(0, 14);
        osc_ph[i]  = $urandom_range(0, 13);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_meas(3'($urandom_range(0, 7)), $urandom_range(0, 40), 1'b0, lat, dones);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ring_osc_freq_meter.md
# ring_osc_freq_meter

Gated edge counter that measures the frequency of one ring-oscillator output against the system clock. It sits directly downstream of `ring_osc`: the seven oscillator taps (`clk_03` … `clk_19`) enter as asynchronous data, and one tap is selected per measurement. Rising edges are counted over a programmable window of `clk` cycles. Control and results connect to logic-analyzer bits in `user_project_wrapper`.

## Interface
Parameters:
- `N_OSC`, 7, number of oscillator inputs.
- `SEL_W`, 3, select width; must satisfy 2**SEL_W ≥ N_OSC.
- `GATE_W`, 16, gate-length width, in clk cycles.
- `CNT_W`, 16, edge-count width.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `osc_in`  in  N_OSC  ring-oscillator taps; asynchronous to `clk`.
- `sel`  in  SEL_W  tap select; sampled on an accepted `start`.
- `gate_len`  in  GATE_W  measurement window in cycles; sampled on an accepted `start`.
- `start`  in  1  single-cycle request; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start until the result is valid.
- `done`  out  1  single-cycle pulse when `count` is updated.
- `count`  out  CNT_W  rising edges seen in the last window; held until the next result.
- `overflow`  out  1  last window saturated `count`; held with `count`.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE → SETTLE on `start`=1. On that edge, `sel` and `gate_len` are latched. The gate counter is loaded with `gate_len` and the edge counter is cleared.
- SETTLE lasts exactly 3 cycles. This flushes the synchronizer after the mux change. No edges are counted in SETTLE.
- SETTLE → DONE directly if the latched `gate_len` is 0. Otherwise SETTLE → MEASURE.
- MEASURE lasts exactly `gate_len` cycles. In each cycle a synchronized rising edge increments the edge counter.
- DONE lasts 1 cycle, then returns to IDLE.
- Edge path:
  - The mux selects `osc_in[sel_q]`.
  - The selected tap passes through a 2-flop synchronizer (s1, s2) and then a history flop (s3).
  - A rising edge is s2 & ~s3.
  - A latched `sel_q` ≥ N_OSC selects constant 0, so the count is 0.
- Arithmetic:
  - The edge counter saturates at 2**CNT_W−1.
  - An edge that arrives while the counter is saturated sets the internal overflow flag.
  - The flag is cleared at start.
- `count` and `overflow` load from the internal counter and flag on the DONE cycle. They are not updated at any other time.
- `start` while `busy` is ignored and has no side effects.
- Accuracy: the measurement is valid only for oscillator frequency < f_clk/2 (Nyquist on the synchronized sample). Higher frequencies alias; this is documented and not detected.
- `rst` asserted in any state returns the block to IDLE within the same cycle (asynchronous) and clears every register, including `count`.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `overflow`=0. FSM = IDLE.
- Let T0 be the rising edge on which `start`=1 is sampled in IDLE.
- `busy`=1 during cycles T1 through T3+G, where G = latched `gate_len`.
- SETTLE occupies T1–T3. MEASURE occupies T4 through T3+G.
- DONE is at T4+G:
  - `done`=1 and `busy`=0 in that cycle.
  - `count` and `overflow` become valid in that cycle.
- A new `start` is accepted at T5+G at the earliest.
- G=0: DONE is at T4, with `count`=0 and `overflow`=0.
- Edge-to-count latency: an oscillator edge is counted 2–3 cycles after it occurs. Edges in the last 2 cycles of the window may be lost, giving ±1 count uncertainty.

## Structure
- Package `ring_meas_pkg` contains:
  - the state typedef `meas_state_t` (IDLE, SETTLE, MEASURE, DONE);
  - localparam `SETTLE_CYCLES` = 3.
- Sub-module `sync_edge_det` holds s1/s2/s3 and produces a one-cycle rising-edge pulse. Its reset is asynchronous, active-high, and clears all three flops to 0.
- The top level holds the mux, the FSM, the gate counter, the saturating edge counter and the output registers.

## Test plan
- Measure case: `osc_in[2]` is a square wave with period 8 clk; sel=2, gate_len=64 → `done` at T68, `count`=8 ±1, `overflow`=0, `busy` high T1–T67.
- Saturation case: CNT_W=4 with a square wave of period 4 clk; gate_len=100 → `count`=15, `overflow`=1.
- Zero gate: gate_len=0 → `done` at T4, `count`=0, `busy` high T1–T3 only.
- Busy lockout: issue a second `start` with different sel/gate_len at T10 of a running measurement → it is ignored; the result uses the original parameters and exactly one `done` pulse occurs.
- Invalid select: sel=7 (N_OSC=7) with all taps toggling → `count`=0, `overflow`=0.
- Reset mid-run: assert `rst` during MEASURE → outputs go to 0 immediately. After release, a fresh start gives a correct result with no stale count.
